// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_n
//  Purpose  : N-input registered valid/ready stream multiplexer. The channel
//             comes from a registered select, or from round-robin arbitration
//             when MUX_RR_ARB_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_n #(
    parameter  int WIDTH    = 8,
    parameter  int N_INPUTS = 4,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]       in_valid,
    output logic [N_INPUTS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic                      rr_mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          beat_cnt
);

    localparam logic [SEL_W:0] c_n_inputs = N_INPUTS[SEL_W:0];

    logic [SEL_W-1:0] r_sel_q;
    logic [SEL_W-1:0] w_active;
    logic             w_req_ok;
    logic             w_slot_free;
    logic             w_transfer;
    logic [WIDTH-1:0] w_active_data;

`ifdef MUX_RR_ARB_EN
    logic             r_rr_mode;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_rr_next;
    logic             w_any_valid;

    // Scan from the farthest offset down so the nearest valid channel to
    // rr_ptr is the one left in w_grant.
    always_comb begin
        logic [SEL_W:0] v_idx;
        v_idx       = '0;
        w_grant     = r_rr_ptr;
        w_any_valid = 1'b0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr_ptr} + k[SEL_W:0];
            if (v_idx >= c_n_inputs) begin
                v_idx = v_idx - c_n_inputs;
            end
            if (in_valid[v_idx[SEL_W-1:0]]) begin
                w_grant     = v_idx[SEL_W-1:0];
                w_any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        logic [SEL_W:0] v_nxt;
        v_nxt     = {1'b0, w_grant} + 1'b1;
        w_rr_next = (v_nxt >= c_n_inputs) ? '0 : v_nxt[SEL_W-1:0];
    end

    assign w_active = r_rr_mode ? w_grant : r_sel_q;
    assign w_req_ok = r_rr_mode ? w_any_valid : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_mode <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            r_rr_mode <= rr_mode;
            if (r_rr_mode && w_transfer) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end
`else
    logic w_unused_rr_mode;
    assign w_unused_rr_mode = rr_mode;
    assign w_active         = r_sel_q;
    assign w_req_ok         = 1'b1;
`endif

    assign w_slot_free   = !out_valid || out_ready;
    assign cur_sel       = w_active;
    assign w_active_data = in_data[w_active*WIDTH +: WIDTH];

    // Only the active channel may see ready; reset masks it so no beat is
    // taken in a reset cycle.
    always_comb begin
        in_ready = '0;
        if (!rst && w_slot_free && w_req_ok) begin
            in_ready[w_active] = 1'b1;
        end
    end

    assign w_transfer = in_valid[w_active] && in_ready[w_active];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            r_sel_q   <= '0;
            sel_err   <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (w_transfer) begin
                out_data  <= w_active_data;
                out_valid <= 1'b1;
                beat_cnt  <= beat_cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            sel_err <= 1'b0;
            if (sel_load) begin
                if ({1'b0, sel} < c_n_inputs) begin
                    r_sel_q <= sel;
                end else begin
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_n
//  Purpose  : Directed self-checking bench for stream_mux_n (N=4 and N=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_n;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] in_data_a;
    logic [3:0]  in_valid_a;
    logic [3:0]  in_ready_a;
    logic [1:0]  sel_a;
    logic        sel_load_a;
    logic        rr_mode_a;
    logic [7:0]  out_data_a;
    logic        out_valid_a;
    logic        out_ready_a;
    logic [1:0]  cur_sel_a;
    logic        sel_err_a;
    logic [15:0] beat_cnt_a;

    logic [23:0] in_data_b;
    logic [2:0]  in_valid_b;
    logic [2:0]  in_ready_b;
    logic [1:0]  sel_b;
    logic        sel_load_b;
    logic [7:0]  out_data_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [1:0]  cur_sel_b;
    logic        sel_err_b;
    logic [3:0]  beat_cnt_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(8), .N_INPUTS(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .sel(sel_a), .sel_load(sel_load_a), .rr_mode(rr_mode_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .cur_sel(cur_sel_a), .sel_err(sel_err_a), .beat_cnt(beat_cnt_a)
    );

    stream_mux_n #(.WIDTH(8), .N_INPUTS(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sel(sel_b), .sel_load(sel_load_b), .rr_mode(1'b0),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .cur_sel(cur_sel_b), .sel_err(sel_err_b), .beat_cnt(beat_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rst = 1'b1;
        in_data_a = '0; in_valid_a = '0; sel_a = '0; sel_load_a = 1'b0;
        rr_mode_a = 1'b0; out_ready_a = 1'b1;
        in_data_b = '0; in_valid_b = '0; sel_b = '0; sel_load_b = 1'b0;
        out_ready_b = 1'b1;
        tick(); tick();
        check("ready_in_reset", {28'd0, in_ready_a}, 32'h0);
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid_a}, 32'h0);
        check("reset_out_data", {24'd0, out_data_a}, 32'h0);
        check("reset_beat_cnt", {16'd0, beat_cnt_a}, 32'h0);
        check("reset_cur_sel", {30'd0, cur_sel_a}, 32'h0);
        check("reset_sel_err", {31'd0, sel_err_a}, 32'h0);

        // Fixed mode: select ch2 and send 0xA5
        sel_a = 2'd2; sel_load_a = 1'b1;
        tick();
        sel_load_a = 1'b0;
        check("t1_cur_sel", {30'd0, cur_sel_a}, 32'd2);
        in_data_a = 32'h00A5_0000; in_valid_a = 4'b0100;
        #1;
        check("t1_in_ready", {28'd0, in_ready_a}, 32'b0100);
        tick();
        check("t1_out_data", {24'd0, out_data_a}, 32'hA5);
        check("t1_out_valid", {31'd0, out_valid_a}, 32'h1);
        check("t1_beat_cnt", {16'd0, beat_cnt_a}, 32'd1);

        // Backpressure holds the beat and blocks all inputs
        in_data_a = 32'h003C_0000; out_ready_a = 1'b0;
        #1;
        check("t2_ready_blocked", {28'd0, in_ready_a}, 32'h0);
        tick();
        check("t2_data_held", {24'd0, out_data_a}, 32'hA5);
        check("t2_valid_held", {31'd0, out_valid_a}, 32'h1);
        check("t2_cnt_held", {16'd0, beat_cnt_a}, 32'd1);
        out_ready_a = 1'b1;
        #1;
        check("t2_ready_release", {28'd0, in_ready_a}, 32'b0100);
        tick();
        check("t2_next_beat", {24'd0, out_data_a}, 32'h3C);
        check("t2_cnt", {16'd0, beat_cnt_a}, 32'd2);

        // Switch to ch1 during a ch2 transfer
        in_data_a = 32'h0011_2200; in_valid_a = 4'b0110;
        sel_a = 2'd1; sel_load_a = 1'b1;
        tick();
        sel_load_a = 1'b0;
        check("t3_old_sel_beat", {24'd0, out_data_a}, 32'h11);
        check("t3_cur_sel", {30'd0, cur_sel_a}, 32'd1);
        tick();
        check("t3_ch1_beat", {24'd0, out_data_a}, 32'h22);
        in_data_a = 32'h0011_3300;
        tick();
        check("t3_ch1_beat2", {24'd0, out_data_a}, 32'h33);
        check("t3_cnt", {16'd0, beat_cnt_a}, 32'd5);
        in_valid_a = '0;
        tick();
        check("drain_valid", {31'd0, out_valid_a}, 32'h0);

`ifdef MUX_RR_ARB_EN
        rr_mode_a = 1'b1;
        in_data_a = 32'hD3D2_D1D0;
        tick();
        in_valid_a = 4'b1111;
        #1;
        check("rr_first_grant", {30'd0, cur_sel_a}, 32'd0);
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_all_data", {24'd0, out_data_a}, {24'd0, 6'h34, rr_exp[i]});
        end
        in_valid_a = 4'b1010;
        rr_exp = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rr_pair_data", {24'd0, out_data_a}, {24'd0, 6'h34, rr_exp[i]});
        end
        check("rr_cnt", {16'd0, beat_cnt_a}, 32'd13);
        in_valid_a = '0;
        #1;
        check("rr_idle_ptr", {30'd0, cur_sel_a}, 32'd2);
        check("rr_idle_ready", {28'd0, in_ready_a}, 32'h0);
        rr_mode_a = 1'b0;
        tick();
        check("rr_exit_sel", {30'd0, cur_sel_a}, 32'd1);
`else
        rr_mode_a = 1'b1;
        in_valid_a = 4'b1000;
        tick();
        check("rr_ignored_sel", {30'd0, cur_sel_a}, 32'd1);
        check("rr_ignored_ready", {28'd0, in_ready_a}, 32'b0010);
        rr_mode_a = 1'b0;
        in_valid_a = '0;
`endif

        // Reset while a beat is held under backpressure
        in_data_a = 32'h0000_7700; in_valid_a = 4'b0010;
        tick();
        check("t6_valid_before", {31'd0, out_valid_a}, 32'h1);
        in_valid_a = '0; out_ready_a = 1'b0; rst = 1'b1;
        #1;
        check("t6_ready_rst", {28'd0, in_ready_a}, 32'h0);
        out_ready_a = 1'b1; in_valid_a = 4'b0010;
        #1;
        check("t6_ready_rst_free", {28'd0, in_ready_a}, 32'h0);
        tick();
        rst = 1'b0; in_valid_a = '0;
        #1;
        check("t6_out_valid", {31'd0, out_valid_a}, 32'h0);
        check("t6_beat_cnt", {16'd0, beat_cnt_a}, 32'h0);
        check("t6_cur_sel", {30'd0, cur_sel_a}, 32'h0);
        check("t6_out_data", {24'd0, out_data_a}, 32'h0);

        // N=3: out-of-range select
        sel_b = 2'd2; sel_load_b = 1'b1;
        tick();
        check("t4_sel_ok", {30'd0, cur_sel_b}, 32'd2);
        check("t4_no_err", {31'd0, sel_err_b}, 32'h0);
        sel_b = 2'd3;
        tick();
        sel_load_b = 1'b0;
        check("t4_err_pulse", {31'd0, sel_err_b}, 32'h1);
        check("t4_sel_kept", {30'd0, cur_sel_b}, 32'd2);
        tick();
        check("t4_err_clear", {31'd0, sel_err_b}, 32'h0);

        // 16 beats through a 4-bit counter wrap it back to 0
        in_valid_b = 3'b100;
        for (int i = 1; i <= 15; i++) begin
            in_data_b = {i[7:0], 16'h0000};
            tick();
        end
        check("wrap_cnt_15", {28'd0, beat_cnt_b}, 32'd15);
        check("wrap_data_15", {24'd0, out_data_b}, 32'd15);
        in_data_b = 24'h100000;
        tick();
        check("wrap_cnt_0", {28'd0, beat_cnt_b}, 32'd0);
        check("wrap_data_16", {24'd0, out_data_b}, 32'h10);
        in_valid_b = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
